// File: rtl/mult8_op_sequencer.sv
// Operand/result handshake wrapper around the 8-bit multiplier control unit and datapath.
// Latency: accept->mul_start 1 cycle, mul_done->out_valid 1 cycle; stalls in HOLD until out_ready.
module mult8_op_sequencer #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_x,
  input  logic [DATA_W-1:0]     in_y,
  output logic [DATA_W-1:0]     mul_x,
  output logic [DATA_W-1:0]     mul_y,
  output logic                  mul_start,
  output logic                  mul_rst,
  input  logic                  mul_done,
  input  logic [2*DATA_W-1:0]   mul_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_res,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      op_count
);

  localparam int TO_W = $clog2(TIMEOUT);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]            state_q, state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]     mul_x_q, mul_x_d;
  logic [DATA_W-1:0]     mul_y_q, mul_y_d;
  logic [2*DATA_W-1:0]   out_res_q, out_res_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]      op_count_q, op_count_d;

  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    mul_x_d       = mul_x_q;
    mul_y_d       = mul_y_q;
    out_res_d     = out_res_q;
    timeout_err_d = timeout_err_q;
    op_count_d    = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mul_x_d = in_x;
          mul_y_d = in_y;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // A DONE still high from the previous op is deliberately not looked at here.
        to_cnt_d = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        to_cnt_d = to_cnt_q + TO_ONE;
        if (mul_done) begin
          out_res_d = mul_res;
          state_d   = ST_HOLD;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_ABORT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          op_count_d = op_count_q + CNT_ONE;
          state_d    = ST_IDLE;
        end
      end
      ST_ABORT: begin
        timeout_err_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      to_cnt_q      <= '0;
      mul_x_q       <= '0;
      mul_y_q       <= '0;
      out_res_q     <= '0;
      timeout_err_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      mul_x_q       <= mul_x_d;
      mul_y_q       <= mul_y_d;
      out_res_q     <= out_res_d;
      timeout_err_q <= timeout_err_d;
      op_count_q    <= op_count_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE) && !RESET;
  assign mul_start   = (state_q == ST_START);
  assign mul_rst     = (state_q == ST_ABORT);
  assign out_valid   = (state_q == ST_HOLD);
  assign mul_x       = mul_x_q;
  assign mul_y       = mul_y_q;
  assign out_res     = out_res_q;
  assign timeout_err = timeout_err_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_mult8_op_sequencer.sv
// Randomized bench for mult8_op_sequencer with a behavioural control-unit/datapath stand-in.
module tb_mult8_op_sequencer;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0, in_y = '0;
  logic [7:0]  mul_x, mul_y;
  logic        mul_start, mul_rst;
  logic        mul_done = 1'b0;
  logic [15:0] mul_res = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_res;
  logic        timeout_err;
  logic [7:0]  op_count;

  int total = 0;
  int bad   = 0;

  // control unit stand-in: 0 = DONE k cycles after start, 1 = DONE stuck high, 2 = never DONE
  int cu_mode  = 0;
  int cu_delay = 5;
  int cu_cnt   = 0;

  logic [7:0] exp_cnt  = '0;
  logic       exp_terr = 1'b0;

  mult8_op_sequencer dut (
    .clk(clk), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_start(mul_start), .mul_rst(mul_rst),
    .mul_done(mul_done), .mul_res(mul_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .timeout_err(timeout_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    mul_done = 1'b0;
    if (cu_mode == 1) begin
      mul_done = 1'b1;
    end else if (cu_cnt > 0) begin
      cu_cnt = cu_cnt - 1;
      if (cu_cnt == 0) mul_done = 1'b1;
    end
    if (mul_start && cu_mode == 0) cu_cnt = cu_delay;
    mul_res = {8'b0, mul_x} * {8'b0, mul_y};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int k, input int lag);
    int n;
    logic [15:0] exp_p;
    exp_p = 16'(int'(x) * int'(y));
    cu_delay = k;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    in_valid = 1'b1; in_x = x; in_y = y;
    tick();
    in_valid = 1'b0; in_x = 8'($urandom); in_y = 8'($urandom);
    total++;
    if (mul_start !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL start_pulse: mul_start=%b in_ready=%b, want 1/0", mul_start, in_ready);
    end
    n = 0;
    do begin
      tick(); n++;
      if (mul_start !== 1'b0) begin
        total++; bad++; $display("FAIL start_width: mul_start still %b after %0d cycles", mul_start, n);
      end
    end while (!out_valid && n < 200);
    total++;
    if (n != k + 1) begin
      bad++; $display("FAIL done_latency: out_valid after %0d cycles, want %0d", n, k + 1);
    end
    total++;
    if (out_res !== exp_p || mul_x !== x || mul_y !== y) begin
      bad++; $display("FAIL product: out_res=%0d mul_x=%0d mul_y=%0d, want %0d %0d %0d",
                      out_res, mul_x, mul_y, exp_p, x, y);
    end
    repeat (lag) begin
      in_valid = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_res !== exp_p || in_ready !== 1'b0 || mul_x !== x) begin
        bad++; $display("FAIL hold: out_valid=%b out_res=%0d in_ready=%b mul_x=%0d, want 1 %0d 0 %0d",
                        out_valid, out_res, in_ready, mul_x, exp_p, x);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== exp_cnt || out_res !== exp_p
        || timeout_err !== exp_terr) begin
      bad++; $display("FAIL handshake: out_valid=%b in_ready=%b op_count=%0d out_res=%0d terr=%b, want 0 1 %0d %0d %b",
                      out_valid, in_ready, op_count, out_res, timeout_err, exp_cnt, exp_p, exp_terr);
    end
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b0 || mul_rst !== 1'b0) begin
      bad++; $display("FAIL reset_comb: in_ready=%b mul_rst=%b, want 0 0", in_ready, mul_rst);
    end
    tick();
    RESET = 1'b0;
    cu_cnt = 0;
    exp_cnt = '0;
    exp_terr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (out_valid !== 1'b0 || mul_start !== 1'b0 || mul_rst !== 1'b0 || timeout_err !== 1'b0
        || op_count !== 8'd0 || out_res !== 16'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_state: ov=%b ms=%b mr=%b te=%b cnt=%0d res=%0d ir=%b",
                      out_valid, mul_start, mul_rst, timeout_err, op_count, out_res, in_ready);
    end
  endtask

  task automatic test_basic();
    cu_mode = 0;
    do_op(8'd12, 8'd13, 10, 0);
    total++;
    if (out_res !== 16'd156 || op_count !== 8'd1) begin
      bad++; $display("FAIL basic: out_res=%0d op_count=%0d, want 156 1", out_res, op_count);
    end
  endtask

  task automatic test_backpressure();
    do_op(8'd255, 8'd255, 3, 5);
    total++;
    if (out_res !== 16'd65025) begin
      bad++; $display("FAIL max_product: out_res=%0d, want 65025", out_res);
    end
  endtask

  task automatic test_timeout();
    int n;
    cu_mode = 2;
    in_valid = 1'b1; in_x = 8'd9; in_y = 8'd9;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      if (out_valid !== 1'b0) begin
        total++; bad++; $display("FAIL timeout_valid: out_valid=%b at cycle %0d, want 0", out_valid, n);
      end
    end while (!mul_rst && n < 200);
    total++;
    if (n != 65) begin
      bad++; $display("FAIL timeout_latency: mul_rst after %0d cycles, want 65", n);
    end
    tick();
    exp_terr = 1'b1;
    total++;
    if (mul_rst !== 1'b0 || timeout_err !== 1'b1 || in_ready !== 1'b1 || op_count !== exp_cnt) begin
      bad++; $display("FAIL timeout_after: mul_rst=%b terr=%b in_ready=%b cnt=%0d, want 0 1 1 %0d",
                      mul_rst, timeout_err, in_ready, op_count, exp_cnt);
    end
    cu_mode = 0;
    do_op(8'd3, 8'd4, 4, 0);
  endtask

  task automatic test_reset_mid_run();
    cu_mode = 0;
    cu_delay = 15;
    in_valid = 1'b1; in_x = 8'd7; in_y = 8'd6;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_cnt = '0;
    exp_terr = 1'b0;
    repeat (20) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 8'd0 || out_res !== 16'd0
          || mul_start !== 1'b0) begin
        bad++; $display("FAIL reset_mid_run: ov=%b ir=%b cnt=%0d res=%0d ms=%b, want 0 1 0 0 0",
                        out_valid, in_ready, op_count, out_res, mul_start);
      end
    end
  endtask

  task automatic test_random();
    cu_mode = 0;
    for (int i = 0; i < 30; i++)
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(0, 3)));
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cu_mode = 1;
    for (int i = 0; i < 256; i++)
      do_op(8'($urandom), 8'($urandom), 1, 0);
    total++;
    if (op_count !== 8'd0) begin
      bad++; $display("FAIL wrap: op_count=%0d, want 0", op_count);
    end
    cu_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
